// File: rtl/multi_cycle_adder.sv
// Digit-serial adder: DIGIT bits per clock over NDIG = WIDTH/DIGIT cycles, result registered at completion.
// Optional macro ADDER_SUB_EN adds the sub port for a - b - cin (cout=0 means borrow).
//
// state  | meaning
// IDLE   | waiting for start; result outputs hold the last result
// RUN    | one digit processed per cycle, busy=1
// DONE   | one-cycle done pulse, result outputs just loaded
module multi_cycle_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [KW-1:0]    r_k;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;

  logic             w_sub_in;
  logic             w_sub_eff;
  logic [WIDTH-1:0] w_beff;
  int               w_idx;
  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT:0]   w_dsum;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_ovf;

`ifdef ADDER_SUB_EN
  logic             r_sub;
  assign w_sub_in  = sub;
  assign w_sub_eff = r_sub;
`else
  assign w_sub_in  = 1'b0;
  assign w_sub_eff = 1'b0;
`endif

  assign w_beff = r_b ^ {WIDTH{w_sub_eff}};

  // r_acc collects finished digits so sum stays stable until the final edge
  always_comb begin
    w_idx      = int'(r_k) * DIGIT;
    w_a_dig    = r_a[w_idx +: DIGIT];
    w_b_dig    = w_beff[w_idx +: DIGIT];
    w_dsum     = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};
    w_acc_next = r_acc;
    w_acc_next[w_idx +: DIGIT] = w_dsum[DIGIT-1:0];
    w_ovf      = (r_a[WIDTH-1] == w_beff[WIDTH-1]) &&
                 (w_acc_next[WIDTH-1] != r_a[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
`ifdef ADDER_SUB_EN
      r_sub   <= 1'b0;
`endif
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
`ifdef ADDER_SUB_EN
            r_sub   <= sub;
`endif
            r_k     <= '0;
            r_carry <= cin ^ w_sub_in;
            r_acc   <= '0;
            r_state <= S_RUN;
            busy    <= 1'b1;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_carry <= w_dsum[DIGIT];
          r_k     <= r_k + KW'(1);
          if (r_k == K_LAST) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            sum     <= w_acc_next;
            cout    <= w_dsum[DIGIT];
            ovf     <= w_ovf;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Scoreboard bench for multi_cycle_adder: a 16/4 instance and an 8/8 instance, random and directed operations.
// Honours ADDER_SUB_EN when defined for both the DUTs and the reference model.
module tb_multi_cycle_adder;

`ifdef ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif
  localparam int M_NORM = 0;
  localparam int M_IGN  = 1;
  localparam int M_ABT  = 2;

  typedef struct {
    logic [15:0] s;
    logic        co;
    logic        ov;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start0, cin0, busy0, done0, cout0, ovf0;
  logic [15:0] a0, b0, sum0;
  logic start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;
`ifdef ADDER_SUB_EN
  logic sub0, sub8;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_cycle_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .cin(cin0),
`ifdef ADDER_SUB_EN
    .sub(sub0),
`endif
    .busy(busy0), .done(done0), .sum(sum0), .cout(cout0), .ovf(ovf0)
  );

  multi_cycle_adder #(.WIDTH(8), .DIGIT(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef ADDER_SUB_EN
    .sub(sub8),
`endif
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned result for sum/cout, signed result range for ovf
  function automatic void model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                input logic cv, input logic sv,
                                output logic [15:0] s, output logic co, output logic ov);
    longint m  = longint'(1) << w;
    longint ua = longint'(av);
    longint ub = longint'(bv);
    longint ci = cv ? 1 : 0;
    longint sa = av[w-1] ? ua - m : ua;
    longint sb = bv[w-1] ? ub - m : ub;
    longint r, sr;
    if (sv) begin
      r  = ua - ub - ci;
      sr = sa - sb - ci;
      co = (ua >= ub + ci);
    end else begin
      r  = ua + ub + ci;
      sr = sa + sb + ci;
      co = (r >= m);
    end
    s  = 16'(r & (m - 1));
    ov = (sr < -(m / 2)) || (sr >= (m / 2));
  endfunction

  task automatic set_in(input int sel, input logic st, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic sv);
    if (sel == 0) begin
      start0 = st; a0 = av; b0 = bv; cin0 = cv;
`ifdef ADDER_SUB_EN
      sub0 = sv;
`endif
    end else begin
      start8 = st; a8 = av[7:0]; b8 = bv[7:0]; cin8 = cv;
`ifdef ADDER_SUB_EN
      sub8 = sv;
`endif
    end
  endtask

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy0 : busy8;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 0) ? done0 : done8;
  endfunction

  function automatic logic [15:0] sum_of(input int sel);
    return (sel == 0) ? sum0 : {8'h00, sum8};
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                        input logic cv, input logic sv, input int mode);
    exp_t e;
    int e0, nd, w, nb;
    bit seen;
    string tag;
    nd  = (sel == 0) ? 4 : 1;
    w   = (sel == 0) ? 16 : 8;
    tag = (sel == 0) ? "dut16" : "dut8";
    if (sel != 0) begin
      av = av & 16'h00FF;
      bv = bv & 16'h00FF;
    end
    set_in(sel, 1'b1, av, bv, cv, sv);
    @(posedge clk);
    #1 e0 = cyc;
    if (mode != M_ABT) begin
      model(w, av, bv, cv, sv & SUB_EN, e.s, e.co, e.ov);
      e.due = e0 + nd;
      if (sel == 0) q0.push_back(e); else q8.push_back(e);
    end
    nb = 0;
    seen = 1'b0;
    for (int i = 1; i <= nd + 4; i++) begin
      @(negedge clk);
      if (i == 1) set_in(sel, 1'b0, av, bv, cv, sv);
      if (busy_of(sel)) nb++;
      if (done_of(sel)) begin
        seen = 1'b1;
        if (mode != M_ABT) break;
      end
      if (mode == M_IGN && i == 2) set_in(sel, 1'b1, ~av, av ^ bv, ~cv, ~sv);
      if (mode == M_IGN && i == 3) set_in(sel, 1'b0, av, bv, cv, sv);
      if (mode == M_ABT && i == 2) rst = 1'b1;
      if (mode == M_ABT && i == 3) begin
        rst = 1'b0;
        check({tag, " abort busy"}, 32'(busy_of(sel)), 32'd0);
        check({tag, " abort done"}, 32'(done_of(sel)), 32'd0);
        check({tag, " abort sum"}, 32'(sum_of(sel)), 32'd0);
      end
    end
    if (mode == M_ABT) begin
      check({tag, " done after abort"}, 32'(seen), 32'd0);
    end else begin
      check({tag, " done seen"}, 32'(seen), 32'd1);
      check({tag, " busy cycles"}, 32'(nb), 32'(nd));
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut16 done with empty scoreboard sum=%0h", sum0);
      end else begin
        e = q0.pop_front();
        check("dut16 sum", 32'(sum0), 32'(e.s));
        check("dut16 cout", 32'(cout0), 32'(e.co));
        check("dut16 ovf", 32'(ovf0), 32'(e.ov));
        check("dut16 latency", 32'(cyc), 32'(e.due));
      end
    end
    if (done8) begin
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dut8 done with empty scoreboard sum=%0h", sum8);
      end else begin
        e = q8.pop_front();
        check("dut8 sum", 32'(sum8), 32'(e.s[7:0]));
        check("dut8 cout", 32'(cout8), 32'(e.co));
        check("dut8 ovf", 32'(ovf8), 32'(e.ov));
        check("dut8 latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_in(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    set_in(1, 1'b1, 16'hFF, 16'hFF, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("dut16 reset busy", 32'(busy0), 32'd0);
    check("dut16 reset done", 32'(done0), 32'd0);
    check("dut16 reset sum", 32'(sum0), 32'd0);
    check("dut16 reset cout", 32'(cout0), 32'd0);
    check("dut16 reset ovf", 32'(ovf0), 32'd0);
    check("dut8 reset busy", 32'(busy8), 32'd0);
    check("dut8 reset sum", 32'(sum8), 32'd0);
    set_in(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, M_NORM);
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, M_NORM);
    run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, M_NORM);
    run_op(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, M_NORM);
    if (SUB_EN) begin
      run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, M_NORM);
      run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, M_NORM);
      run_op(0, 16'h0007, 16'h0007, 1'b1, 1'b1, M_NORM);
    end
    run_op(0, 16'h1111, 16'h2222, 1'b0, 1'b0, M_IGN);
    run_op(0, 16'hAAAA, 16'h5555, 1'b1, 1'b0, M_ABT);
    run_op(0, 16'h0F0F, 16'hF0F1, 1'b0, 1'b0, M_NORM);
    run_op(1, 16'h0080, 16'h0080, 1'b1, 1'b0, M_NORM);
    run_op(1, 16'h007F, 16'h0001, 1'b0, 1'b0, M_NORM);
    run_op(1, 16'h0040, 16'h0020, 1'b0, 1'b0, M_IGN);

    for (int i = 0; i < 40; i++)
      run_op(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), M_NORM);
    for (int i = 0; i < 15; i++)
      run_op(1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), M_NORM);

    repeat (6) @(negedge clk);
    check("dut16 scoreboard drained", 32'(q0.size()), 32'd0);
    check("dut8 scoreboard drained", 32'(q8.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_cycle_adder.md
MULTI_CYCLE_ADDER -- requirements
Module: multi_cycle_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, giving the bits added per cycle; WIDTH SHALL be a multiple of DIGIT, and NDIG = WIDTH/DIGIT.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port start, input, 1 bit: request a new operation.
REQ-006 Port a, input, WIDTH bits: operand A.
REQ-007 Port b, input, WIDTH bits: operand B.
REQ-008 Port cin, input, 1 bit: carry-in (borrow-in when subtracting).
REQ-009 Port sub, input, 1 bit: subtract select; present only under ADDER_SUB_EN.
REQ-010 Port busy, output, 1 bit: high while an operation is in progress.
REQ-011 Port done, output, 1 bit: one-cycle completion pulse.
REQ-012 Port sum, output, WIDTH bits: registered result.
REQ-013 Port cout, output, 1 bit: carry out of the MSB.
REQ-014 Port ovf, output, 1 bit: two's-complement overflow.

Function
REQ-015 The FSM SHALL have three states, IDLE, RUN and DONE, with busy = (state == RUN) and done = (state == DONE).
REQ-016 In IDLE, start=1 at an edge (E0) SHALL capture a, b, cin (and sub), clear the digit index k to 0, load carry = cin ^ sub_eff, and enter RUN.
REQ-017 sub_eff SHALL be the captured sub when ADDER_SUB_EN is defined, else 0; the effective B SHALL be b ^ {WIDTH{sub_eff}}.
REQ-018 In each RUN cycle, the digit k slice of the result SHALL equal a[k] + Beff[k] + carry, and the carry register SHALL take that digit's carry-out; k then increments.
REQ-019 At the edge that processes digit NDIG-1 (edge E_NDIG), the FSM SHALL enter DONE and load sum, cout and ovf in the same edge.
REQ-020 Latency: done SHALL be high exactly in the cycle following E_NDIG, and busy SHALL be high in the NDIG cycles following E0.
REQ-021 DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-022 start SHALL be ignored in RUN and DONE; no operation is queued. In that case the captured operands are unchanged and outputs are unaffected.
REQ-023 sum, cout and ovf SHALL hold their values from DONE until the next DONE; they SHALL NOT change during RUN.
REQ-024 ovf SHALL be (a[MSB] == Beff[MSB]) && (sum[MSB] != a[MSB]).
REQ-025 cout SHALL be the raw carry out of bit WIDTH-1. When subtracting, cout=0 means a borrow occurred.
REQ-026 With NDIG=1, the block SHALL complete in one RUN cycle: done follows E1.

Reset
REQ-027 When rst=1 at an edge, the FSM SHALL enter IDLE and clear k, carry, the operand registers, sum, cout and ovf to 0.
REQ-028 After a reset edge, busy and done SHALL be 0.
REQ-029 rst SHALL have priority over start.
REQ-030 A reset asserted during RUN SHALL abort the operation with no done pulse.

Configuration
REQ-031 With macro ADDER_SUB_EN defined, the sub port SHALL exist and select a - b - cin: carry0 = ~cin and B is inverted.
REQ-032 Without ADDER_SUB_EN, the sub port SHALL be absent and the block SHALL be add-only, computing a + b + cin.

Verification
REQ-033 WIDTH=16, DIGIT=4: start with a=0x1234, b=0x4321, cin=0 -> done in the 4th cycle after E0 with sum=0x5555, cout=0, ovf=0; busy high for exactly 4 cycles.
REQ-034 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; also a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-035 With ADDER_SUB_EN: sub=1, a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0; sub=1, a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1.
REQ-036 Pulse start again 2 cycles after E0 with different operands -> ignored; the first result appears unchanged and exactly one done pulse occurs.
REQ-037 Assert rst for 1 cycle during RUN -> the next cycle shows busy=0, done=0, sum=0, and no done pulse follows; a new start is then accepted normally.
REQ-038 WIDTH=8, DIGIT=8: a=0x80, b=0x80, cin=1 -> done in the cycle after E1 with sum=0x01, cout=1, ovf=1.
